// File: rtl/maxpool_pkg.sv
// Shared constants and helpers for the 2x2 binary max-pool sequencer.
package maxpool_pkg;

  localparam logic [3:0] MODE_BWN = 4'b0001;
  localparam logic [3:0] MODE_C2  = 4'b0010;
  localparam logic [3:0] MODE_C3  = 4'b0100;
  localparam logic [3:0] MODE_FC  = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic is_pool_mode(input logic [3:0] mode);
    return (mode == MODE_BWN) || (mode == MODE_C3);
  endfunction

  function automatic logic is_one_hot(input logic [3:0] mode);
    return (mode != 4'd0) && ((mode & (mode - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/maxpool_win_ctrl_pool_pos_cnt.sv
// Raster row/column counter: sync clear, enable, end-of-row wrap and last-pixel flag.
module pool_pos_cnt #(
  parameter int W  = 12,
  parameter int H  = 12,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col,
  output logic          last
);

  localparam logic [CW-1:0] COL_MAX = CW'(W - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(H - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col == COL_MAX) begin
        col <= '0;
        row <= (row == ROW_MAX) ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

  assign last = (row == ROW_MAX) && (col == COL_MAX);

endmodule

// File: rtl/maxpool_win_ctrl.sv
// Frame sequencer for the streaming 2x2 binary max-pool datapath: position tracking,
// shift gating, frame clear, OR/AND select and stride-2 window-valid generation.
module maxpool_win_ctrl
  import maxpool_pkg::*;
#(
  parameter int W  = 12,
  parameter int H  = 12,
  parameter int CW = $clog2(W),
  parameter int RW = $clog2(H)
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iSTART,
  input  logic [3:0]    iMODE,
  input  logic          iPOL_INV,
  input  logic          iVALID,
  output logic          oCLR,
  output logic          oPOOL_EN,
  output logic          oSEL_AND,
  output logic          oBYPASS,
  output logic          oVALID,
  output logic [RW-1:0] oROW,
  output logic [CW-1:0] oCOL,
  output logic          oBUSY,
  output logic          oDONE,
  output logic          oERR
);

  state_t        state;
  logic [RW-1:0] cnt_row;
  logic [CW-1:0] cnt_col;
  logic          cnt_last;
  logic          accept;

  // iSTART takes priority over a same-cycle pixel, which is dropped.
  assign accept = (state == ST_RUN) && iVALID && !iSTART;

  pool_pos_cnt #(
    .W  (W),
    .H  (H),
    .CW (CW),
    .RW (RW)
  ) u_pos (
    .clk  (iCLK),
    .rst  (iRST),
    .clr  (iSTART),
    .en   (accept),
    .row  (cnt_row),
    .col  (cnt_col),
    .last (cnt_last)
  );

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state    <= ST_IDLE;
      oCLR     <= 1'b0;
      oERR     <= 1'b0;
      oDONE    <= 1'b0;
      oVALID   <= 1'b0;
      oSEL_AND <= 1'b0;
      oBYPASS  <= 1'b0;
      oROW     <= '0;
      oCOL     <= '0;
    end else begin
      oCLR   <= 1'b0;
      oERR   <= 1'b0;
      oDONE  <= 1'b0;
      oVALID <= 1'b0;
      if (iSTART) begin
        if (is_one_hot(iMODE)) begin
          state    <= ST_RUN;
          oCLR     <= 1'b1;
          oSEL_AND <= iPOL_INV;
          oBYPASS  <= !is_pool_mode(iMODE);
          oROW     <= '0;
          oCOL     <= '0;
        end else begin
          // An illegal restart also abandons any frame in flight.
          oERR  <= 1'b1;
          state <= ST_IDLE;
        end
      end else begin
        case (state)
          ST_IDLE: ;
          ST_RUN: begin
            if (iVALID) begin
              oROW   <= cnt_row;
              oCOL   <= cnt_col;
              // Odd row and odd col close a stride-2 window; odd trailing row/col never qualify.
              oVALID <= oBYPASS || (cnt_row[0] && cnt_col[0]);
              if (cnt_last) begin
                state <= ST_DRAIN;
                oDONE <= 1'b1;
              end
            end
          end
          ST_DRAIN: state <= ST_IDLE;
          default:  state <= ST_IDLE;
        endcase
      end
    end
  end

  assign oPOOL_EN = (state == ST_RUN) && iVALID;
  assign oBUSY    = (state != ST_IDLE);

endmodule
